// File: rtl/ysyx_22040127_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_muldiv_pkg
// Shared definitions for the M-extension sequencer: datapath width, the
// req_op encoding used by execute decode, controller state encoding and a
// few small op-classification helpers.
// ---------------------------------------------------------------------------
package ysyx_22040127_muldiv_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 4;

  // M-extension op encodings as presented on req_op
  localparam logic [OPW-1:0] OP_MUL    = 4'd0;
  localparam logic [OPW-1:0] OP_MULH   = 4'd1;
  localparam logic [OPW-1:0] OP_MULHSU = 4'd2;
  localparam logic [OPW-1:0] OP_MULHU  = 4'd3;
  localparam logic [OPW-1:0] OP_MULW   = 4'd4;
  localparam logic [OPW-1:0] OP_DIV    = 4'd5;
  localparam logic [OPW-1:0] OP_DIVU   = 4'd6;
  localparam logic [OPW-1:0] OP_REM    = 4'd7;
  localparam logic [OPW-1:0] OP_REMU   = 4'd8;
  localparam logic [OPW-1:0] OP_DIVW   = 4'd9;
  localparam logic [OPW-1:0] OP_DIVUW  = 4'd10;
  localparam logic [OPW-1:0] OP_REMW   = 4'd11;
  localparam logic [OPW-1:0] OP_REMUW  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic op_is_div(input logic [OPW-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMUW);
  endfunction

  function automatic logic op_is_wdiv(input logic [OPW-1:0] op);
    return (op >= OP_DIVW) && (op <= OP_REMUW);
  endfunction

  function automatic logic op_is_rem(input logic [OPW-1:0] op);
    return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

endpackage

// File: rtl/ysyx_22040127_muldiv_prep.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_muldiv_prep
// Purely combinational operand preparation for an incoming M-extension op.
//   i_op, i_src1, i_src2   raw request from execute
//   o_src1, o_src2         operands as the mul/div units should see them
//   o_mul_sign1/2, o_div_sign  signedness controls
//   o_is_mul               op goes to the multiplier
//   o_special              answered without starting any unit
//   o_special_result       the answer for that case
// ---------------------------------------------------------------------------
module ysyx_22040127_muldiv_prep
  import ysyx_22040127_muldiv_pkg::*;
(
  input  logic [OPW-1:0]  i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic [XLEN-1:0] o_src1,
  output logic [XLEN-1:0] o_src2,
  output logic            o_mul_sign1,
  output logic            o_mul_sign2,
  output logic            o_div_sign,
  output logic            o_is_mul,
  output logic            o_special,
  output logic [XLEN-1:0] o_special_result
);

  logic w_is_div;
  logic w_is_w;
  logic w_is_rem;
  logic w_zero;
  logic w_ovf;

  // Classification, operand extension and divide special-case detection.
  // W divides look only at the low words, so zero/overflow are judged there.
  // Encodings above remuw are treated as special with a zero result so the
  // controller never waits on a unit that was not started.
  always_comb begin
    o_is_mul    = (i_op <= OP_MULW);
    w_is_div    = op_is_div(i_op);
    w_is_w      = op_is_wdiv(i_op);
    w_is_rem    = op_is_rem(i_op);
    o_div_sign  = (i_op == OP_DIV) || (i_op == OP_REM) || (i_op == OP_DIVW) || (i_op == OP_REMW);
    o_mul_sign1 = (i_op != OP_MULHU);
    o_mul_sign2 = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULW);

    o_src1 = i_src1;
    o_src2 = i_src2;
    if (w_is_w) begin
      o_src1 = o_div_sign ? sext32(i_src1[31:0]) : {{(XLEN-32){1'b0}}, i_src1[31:0]};
      o_src2 = o_div_sign ? sext32(i_src2[31:0]) : {{(XLEN-32){1'b0}}, i_src2[31:0]};
    end

    w_zero = w_is_w ? (i_src2[31:0] == 32'd0) : (i_src2 == '0);
    if (w_is_w)
      w_ovf = o_div_sign && (i_src1[31:0] == 32'h8000_0000) && (i_src2[31:0] == 32'hFFFF_FFFF);
    else
      w_ovf = o_div_sign && (i_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&i_src2);

    o_special        = (w_is_div && (w_zero || w_ovf)) || (!o_is_mul && !w_is_div);
    o_special_result = '0;
    if (w_is_div && w_zero) begin
      if (w_is_rem)
        o_special_result = w_is_w ? sext32(i_src1[31:0]) : i_src1;
      else
        o_special_result = '1;
    end else if (w_is_div && w_ovf && !w_is_rem) begin
      o_special_result = w_is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

endmodule

// File: rtl/ysyx_22040127_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22040127_muldiv_ctrl
// Execute-stage sequencer for the shared 3-stage multiplier and iterative
// divider. Accepts one op per req handshake, starts the right unit with
// prepared operands, answers divide special cases directly and holds the
// result until resp_ready.
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_op/req_src1/req_src2   request side
//   flush                                          kill in-flight op
//   mul_start/mul_sign1/mul_sign2/mul_ok/mul_hi/mul_lo   multiplier side
//   div_start/div_sign/div_ready/div_quo/div_rem         divider side
//   op_src1/op_src2                                latched operands to both units
//   resp_valid/resp_ready/resp_data                response side
//   busy                                           controller not idle
// ---------------------------------------------------------------------------
module ysyx_22040127_muldiv_ctrl
  import ysyx_22040127_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            mul_start,
  output logic            mul_sign1,
  output logic            mul_sign2,
  input  logic            mul_ok,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic            div_start,
  output logic            div_sign,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem,
  output logic [XLEN-1:0] op_src1,
  output logic [XLEN-1:0] op_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  state_e          r_state;
  state_e          w_next;
  logic [OPW-1:0]  r_op;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic            r_mul_sign1;
  logic            r_mul_sign2;
  logic            r_div_sign;
  logic            r_first;
  logic [XLEN-1:0] r_resp_data;

  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic            w_mul_sign1;
  logic            w_mul_sign2;
  logic            w_div_sign;
  logic            w_is_mul;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;
  logic            w_accept;
  logic            w_drain_done;
  logic [XLEN-1:0] w_mul_result;
  logic [XLEN-1:0] w_div_raw;
  logic [XLEN-1:0] w_div_result;

  ysyx_22040127_muldiv_prep u_prep (
    .i_op             (req_op),
    .i_src1           (req_src1),
    .i_src2           (req_src2),
    .o_src1           (w_src1),
    .o_src2           (w_src2),
    .o_mul_sign1      (w_mul_sign1),
    .o_mul_sign2      (w_mul_sign2),
    .o_div_sign       (w_div_sign),
    .o_is_mul         (w_is_mul),
    .o_special        (w_special),
    .o_special_result (w_special_result)
  );

  // req_ready is also gated by rst so that every output reads 0 while reset
  // is held, including this one, which would otherwise be 1 in IDLE.
  assign req_ready    = (r_state == S_IDLE) && !flush && rst;
  assign w_accept     = req_valid && req_ready;
  assign w_drain_done = op_is_div(r_op) ? div_ready : mul_ok;

  assign mul_start  = (r_state == S_MUL_WAIT) && r_first;
  assign div_start  = (r_state == S_DIV_WAIT) && r_first;
  assign mul_sign1  = r_mul_sign1;
  assign mul_sign2  = r_mul_sign2;
  assign div_sign   = r_div_sign;
  assign op_src1    = r_src1;
  assign op_src2    = r_src2;
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != S_IDLE);

  // Result selection from whichever unit the latched op targeted.
  always_comb begin
    case (r_op)
      OP_MUL:  w_mul_result = mul_lo;
      OP_MULW: w_mul_result = sext32(mul_lo[31:0]);
      default: w_mul_result = mul_hi;
    endcase
    w_div_raw    = op_is_rem(r_op) ? div_rem : div_quo;
    w_div_result = op_is_wdiv(r_op) ? sext32(w_div_raw[31:0]) : w_div_raw;
  end

  // Next-state logic. Flush in a wait state normally drains the unit, but
  // if the done pulse arrives in that same cycle there is nothing left to
  // drain and we go straight back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_special ? S_RESP : (w_is_mul ? S_MUL_WAIT : S_DIV_WAIT);
      end
      S_MUL_WAIT: begin
        if (flush)       w_next = mul_ok ? S_IDLE : S_DRAIN;
        else if (mul_ok) w_next = S_RESP;
      end
      S_DIV_WAIT: begin
        if (flush)          w_next = div_ready ? S_IDLE : S_DRAIN;
        else if (div_ready) w_next = S_RESP;
      end
      S_RESP: begin
        if (flush || resp_ready) w_next = S_IDLE;
      end
      S_DRAIN: begin
        if (w_drain_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Op/operand latches and result capture. r_first marks the first cycle of
  // a wait state, which is the only cycle the start pulse is driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op        <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_mul_sign1 <= 1'b0;
      r_mul_sign2 <= 1'b0;
      r_div_sign  <= 1'b0;
      r_first     <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_first <= w_accept && !w_special;
      if (w_accept) begin
        r_op        <= req_op;
        r_src1      <= w_src1;
        r_src2      <= w_src2;
        r_mul_sign1 <= w_mul_sign1;
        r_mul_sign2 <= w_mul_sign2;
        r_div_sign  <= w_div_sign;
        if (w_special) r_resp_data <= w_special_result;
      end
      if ((r_state == S_MUL_WAIT) && mul_ok && !flush)
        r_resp_data <= w_mul_result;
      if ((r_state == S_DIV_WAIT) && div_ready && !flush)
        r_resp_data <= w_div_result;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040127_muldiv_ctrl
// Self-checking bench: behavioural multiplier/divider models answer the
// start pulses, a vector table drives ops whose expected results go into a
// queue, and hand-written sequences cover flush, hold, reset and done races.
// ---------------------------------------------------------------------------
module tb_ysyx_22040127_muldiv_ctrl;
  import ysyx_22040127_muldiv_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [OPW-1:0]  req_op = '0;
  logic [XLEN-1:0] req_src1 = '0;
  logic [XLEN-1:0] req_src2 = '0;
  logic            flush = 1'b0;
  logic            mul_start, mul_sign1, mul_sign2, mul_ok;
  logic [XLEN-1:0] mul_hi = '0, mul_lo = '0;
  logic            div_start, div_sign, div_ready;
  logic [XLEN-1:0] div_quo = '0, div_rem = '0;
  logic [XLEN-1:0] op_src1, op_src2;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  logic mulOkModel = 1'b0, mulOkInject = 1'b0;
  logic divOkModel = 1'b0, divOkInject = 1'b0;
  assign mul_ok    = mulOkModel | mulOkInject;
  assign div_ready = divOkModel | divOkInject;

  int testsRun = 0;
  int testsFailed = 0;
  int mulStarts = 0;
  int divStarts = 0;
  int mulCnt = 0;
  int divCnt = 0;
  int divLat = 8;
  logic [XLEN-1:0] expQ[$];

  ysyx_22040127_muldiv_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .mul_start(mul_start), .mul_sign1(mul_sign1), .mul_sign2(mul_sign2),
    .mul_ok(mul_ok), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_sign(div_sign), .div_ready(div_ready),
    .div_quo(div_quo), .div_rem(div_rem),
    .op_src1(op_src1), .op_src2(op_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: done pulse three cycles after the start cycle.
  logic [127:0] mA, mB, mP;
  always @(posedge clk) begin
    if (mul_start) begin
      mulStarts <= mulStarts + 1;
      mA = mul_sign1 ? {{64{op_src1[63]}}, op_src1} : {64'd0, op_src1};
      mB = mul_sign2 ? {{64{op_src2[63]}}, op_src2} : {64'd0, op_src2};
      mP = mA * mB;
      mul_hi <= mP[127:64];
      mul_lo <= mP[63:0];
      mulCnt <= 3;
      mulOkModel <= 1'b0;
    end else begin
      mulOkModel <= (mulCnt == 2);
      if (mulCnt != 0) mulCnt <= mulCnt - 1;
    end
  end

  // Divider model with a bench-selectable latency.
  always @(posedge clk) begin
    if (div_start) begin
      divStarts <= divStarts + 1;
      if (op_src2 == 64'd0) begin
        div_quo <= '1;
        div_rem <= op_src1;
      end else if (div_sign) begin
        div_quo <= $signed(op_src1) / $signed(op_src2);
        div_rem <= $signed(op_src1) % $signed(op_src2);
      end else begin
        div_quo <= op_src1 / op_src2;
        div_rem <= op_src1 % op_src2;
      end
      divCnt <= divLat;
      divOkModel <= 1'b0;
    end else begin
      divOkModel <= (divCnt == 2);
      if (divCnt != 0) divCnt <= divCnt - 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting", name);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      failTimeout("req_ready");
      ok = 0;
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1;
  endtask

  task automatic waitResp(output int lat, output bit got);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = resp_valid;
  endtask

  task automatic consumeResp(input string name);
    int lat;
    bit got;
    waitResp(lat, got);
    if (got) begin
      checkOutput(name, resp_data, expQ.pop_front());
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end else begin
      failTimeout(name);
      void'(expQ.pop_front());
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          special;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    int lat, m0, d0, expMul, expDiv;
    bit ok, got;
    logic [63:0] held;

    vecs[0]  = '{OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0};
    vecs[1]  = '{OP_DIVW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[2]  = '{OP_REMU,   64'h1234, 64'd0, 64'h1234, 1'b1};
    vecs[3]  = '{OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
    vecs[4]  = '{OP_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    vecs[5]  = '{OP_MUL,    64'd3, 64'd5, 64'd15, 1'b0};
    vecs[6]  = '{OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
    vecs[7]  = '{OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[8]  = '{OP_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[9]  = '{OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[10] = '{OP_DIVU,   64'd100, 64'd7, 64'd14, 1'b0};
    vecs[11] = '{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[12] = '{OP_REMW,   64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[13] = '{OP_DIVUW,  64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 1'b0};
    vecs[14] = '{OP_REMUW,  64'h5_0000_0007, 64'h1_0000_0000, 64'd7, 1'b1};
    vecs[15] = '{OP_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[16] = '{OP_DIV,    64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[17] = '{OP_REMW,   64'h8000_0000, 64'h0_FFFF_FFFF, 64'd0, 1'b1};
    vecs[18] = '{OP_DIVUW,  64'd5, 64'h7_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst req_ready", req_ready, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst resp_valid", resp_valid, 0);
    checkOutput("rst mul_start", mul_start, 0);
    checkOutput("rst mul_sign1", mul_sign1, 0);
    checkOutput("rst resp_data", resp_data, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle req_ready", req_ready, 1);

    // mulhu: unsigned controls, single start pulse
    expQ.push_back(64'd1);
    applyStimulus(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, ok);
    if (ok) begin
      checkOutput("mulhu mul_start", mul_start, 1);
      checkOutput("mulhu mul_sign1", mul_sign1, 0);
      checkOutput("mulhu mul_sign2", mul_sign2, 0);
      checkOutput("mulhu req_ready busy", req_ready, 0);
      @(negedge clk);
      checkOutput("mulhu start one pulse", mul_start, 0);
      consumeResp("mulhu data");
    end else void'(expQ.pop_front());

    // divw: sign-extended low word and signed divide
    expQ.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(OP_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ok);
    if (ok) begin
      checkOutput("divw op_src1", op_src1, 64'hFFFF_FFFF_FFFF_FFF9);
      checkOutput("divw op_src2", op_src2, 64'd2);
      checkOutput("divw div_sign", div_sign, 1);
      checkOutput("divw div_start", div_start, 1);
      consumeResp("divw data");
    end else void'(expQ.pop_front());

    // Vector table through the scoreboard
    for (int i = 0; i < NV; i++) begin
      m0 = mulStarts;
      d0 = divStarts;
      expMul = (!vecs[i].special && vecs[i].op <= OP_MULW) ? 1 : 0;
      expDiv = (!vecs[i].special && vecs[i].op > OP_MULW) ? 1 : 0;
      expQ.push_back(vecs[i].exp);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, ok);
      if (!ok) begin
        void'(expQ.pop_back());
        continue;
      end
      waitResp(lat, got);
      if (got) begin
        if (vecs[i].special) checkOutput($sformatf("vec%0d latency", i), lat, 1);
        checkOutput($sformatf("vec%0d data", i), resp_data, expQ.pop_front());
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput($sformatf("vec%0d mul starts", i), mulStarts - m0, expMul);
        checkOutput($sformatf("vec%0d div starts", i), divStarts - d0, expDiv);
      end else begin
        failTimeout($sformatf("vec%0d resp", i));
        void'(expQ.pop_front());
      end
    end

    // RESP hold with resp_ready low, then no accept on the releasing edge
    expQ.push_back(64'd15);
    applyStimulus(OP_MUL, 64'd3, 64'd5, ok);
    if (ok) begin
      waitResp(lat, got);
      if (got) begin
        held = expQ.pop_front();
        req_valid = 1'b1;
        req_op = OP_MUL;
        req_src1 = 64'd1;
        req_src2 = 64'd1;
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("hold%0d resp_valid", k), resp_valid, 1);
          checkOutput($sformatf("hold%0d resp_data", k), resp_data, held);
          checkOutput($sformatf("hold%0d req_ready", k), req_ready, 0);
          @(negedge clk);
        end
        resp_ready = 1'b1;
        checkOutput("release req_ready", req_ready, 0);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("release no accept", busy, 0);
      end else begin
        failTimeout("hold resp");
        void'(expQ.pop_front());
      end
    end else void'(expQ.pop_front());

    // Flush 5 cycles into DIV_WAIT: drain until the divider finishes
    divLat = 12;
    applyStimulus(OP_DIVU, 64'd100, 64'd7, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      lat = 0;
      while (!div_ready && lat < 30) begin
        checkOutput("drain busy", busy, 1);
        checkOutput("drain req_ready", req_ready, 0);
        checkOutput("drain resp_valid", resp_valid, 0);
        @(negedge clk);
        lat++;
      end
      if (div_ready) begin
        @(negedge clk);
        checkOutput("drain done busy", busy, 0);
        checkOutput("drain done req_ready", req_ready, 1);
        checkOutput("drain done resp_valid", resp_valid, 0);
      end else failTimeout("drain div_ready");
    end
    divLat = 8;

    // Flush in RESP drops the result
    applyStimulus(OP_DIVU, 64'd5, 64'd0, ok);
    if (ok) begin
      checkOutput("resp flush resp_valid before", resp_valid, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("resp flush resp_valid", resp_valid, 0);
      checkOutput("resp flush busy", busy, 0);
    end

    // Done and flush in the same WAIT cycle: straight to IDLE
    divLat = 6;
    applyStimulus(OP_DIVU, 64'd100, 64'd7, ok);
    if (ok) begin
      lat = 0;
      while (!div_ready && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      if (div_ready) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("done+flush busy", busy, 0);
        checkOutput("done+flush resp_valid", resp_valid, 0);
      end else failTimeout("done+flush div_ready");
    end
    divLat = 8;

    // Done pulses in IDLE are ignored
    mulOkInject = 1'b1;
    divOkInject = 1'b1;
    @(negedge clk);
    mulOkInject = 1'b0;
    divOkInject = 1'b0;
    checkOutput("idle done busy", busy, 0);
    checkOutput("idle done resp_valid", resp_valid, 0);

    // Asynchronous reset in the middle of DIV_WAIT
    divLat = 10;
    applyStimulus(OP_DIV, 64'd1000, 64'd3, ok);
    if (ok) begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("async rst busy", busy, 0);
      checkOutput("async rst req_ready", req_ready, 0);
      checkOutput("async rst op_src1", op_src1, 0);
      checkOutput("async rst div_sign", div_sign, 0);
      checkOutput("async rst resp_data", resp_data, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      checkOutput("post rst busy", busy, 0);
    end
    divLat = 8;

    // Normal operation resumes after reset
    expQ.push_back(64'd14);
    applyStimulus(OP_DIVU, 64'd100, 64'd7, ok);
    if (ok) consumeResp("post rst divu");
    else void'(expQ.pop_front());

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
